// File: rtl/fft_data_ram_param.sv
// fft_data_ram_param
//   Working memory for an in-place radix-2 FFT of N = 2^LOG2N complex points.
//   Samples stream in through a valid/ready port. Each sample goes to
//   bitrev(index) when BITREV_IN=1, or to index when BITREV_IN=0. While the
//   block is computing, the butterfly engine uses two registered read ports and
//   two write ports. A compute_done strobe starts the unload, which streams the
//   results out in natural order with backpressure.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   in_valid/in_ready        load handshake (in_ready high while loading)
//   in_re, in_im             load sample (DW-bit signed each)
//   init_flag                high from load completion until unload completes
//   rd_en, rd_addr1/2        butterfly read request (COMPUTE only)
//   rd_re1/im1, rd_re2/im2   registered read data, latency 1, held when idle
//   wr_en, wr_addr1/2        butterfly write request (COMPUTE only)
//   wr_re1/im1, wr_re2/im2   butterfly write data; port 2 wins on equal address
//   compute_done             single-cycle strobe that starts the unload
//   out_valid/out_ready      unload handshake
//   out_re, out_im           output sample
//   out_idx                  natural-order index of the output sample
//   out_last                 high with the sample at index N-1
module fft_data_ram_param #(
  parameter int DW        = 24,
  parameter int LOG2N     = 3,
  parameter int BITREV_IN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_re,
  input  logic [DW-1:0]    in_im,
  output logic             init_flag,
  input  logic             rd_en,
  input  logic [LOG2N-1:0] rd_addr1,
  input  logic [LOG2N-1:0] rd_addr2,
  output logic [DW-1:0]    rd_re1,
  output logic [DW-1:0]    rd_im1,
  output logic [DW-1:0]    rd_re2,
  output logic [DW-1:0]    rd_im2,
  input  logic             wr_en,
  input  logic [LOG2N-1:0] wr_addr1,
  input  logic [LOG2N-1:0] wr_addr2,
  input  logic [DW-1:0]    wr_re1,
  input  logic [DW-1:0]    wr_im1,
  input  logic [DW-1:0]    wr_re2,
  input  logic [DW-1:0]    wr_im2,
  input  logic             compute_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_re,
  output logic [DW-1:0]    out_im,
  output logic [LOG2N-1:0] out_idx,
  output logic             out_last
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_UNLOAD  = 2'd2
  } state_t;

  state_t state, state_next;

  // Real part occupies the high half of each word.
  logic [2*DW-1:0] mem [N];

  logic [LOG2N-1:0] cnt;
  logic [LOG2N-1:0] load_addr;
  logic [LOG2N-1:0] next_idx;
  logic             load_fire;
  logic             load_last;
  logic             out_fire;
  logic             unload_done;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

  assign in_ready    = (state == S_LOAD);
  assign load_fire   = in_valid && in_ready;
  assign load_last   = load_fire && (cnt == LAST_IDX);
  assign load_addr   = (BITREV_IN != 0) ? bitrev(cnt) : cnt;
  assign out_fire    = (state == S_UNLOAD) && out_valid && out_ready;
  assign unload_done = out_fire && out_last;
  assign next_idx    = out_idx + LOG2N'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_LOAD:    if (load_last)    state_next = S_COMPUTE;
      S_COMPUTE: if (compute_done) state_next = S_UNLOAD;
      S_UNLOAD:  if (unload_done)  state_next = S_LOAD;
      default:   state_next = S_LOAD;
    endcase
  end

  // Storage is not cleared by reset. A write is suppressed only while rst is
  // high. When both butterfly ports write the same address, the port-2
  // assignment comes last and therefore wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_fire) begin
        mem[load_addr] <= {in_re, in_im};
      end
      if ((state == S_COMPUTE) && wr_en) begin
        mem[wr_addr1] <= {wr_re1, wr_im1};
        mem[wr_addr2] <= {wr_re2, wr_im2};
      end
    end
  end

  // Butterfly read ports sample mem before same-edge writes (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_re1 <= '0;
      rd_im1 <= '0;
      rd_re2 <= '0;
      rd_im2 <= '0;
    end else if ((state == S_COMPUTE) && rd_en) begin
      {rd_re1, rd_im1} <= mem[rd_addr1];
      {rd_re2, rd_im2} <= mem[rd_addr2];
    end
  end

  // Load counter, init_flag and the unload output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      init_flag <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      unique case (state)
        S_LOAD: begin
          if (load_fire) begin
            cnt <= cnt + LOG2N'(1);
          end
          if (load_last) begin
            init_flag <= 1'b1;
          end
        end
        S_COMPUTE: begin
          if (compute_done) begin
            {out_re, out_im} <= mem[0];
            out_idx          <= '0;
            out_last         <= 1'b0;
            out_valid        <= 1'b1;
          end
        end
        S_UNLOAD: begin
          if (out_fire) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_idx   <= '0;
              init_flag <= 1'b0;
              cnt       <= '0;
            end else begin
              {out_re, out_im} <= mem[next_idx];
              out_idx          <= next_idx;
              out_last         <= (next_idx == LAST_IDX);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_data_ram_param.sv
module tb_fft_data_ram_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: DW=24, LOG2N=3, BITREV_IN=1
  logic        a_in_valid, a_in_ready, a_init_flag, a_rd_en, a_wr_en, a_cd;
  logic        a_out_valid, a_out_ready, a_out_last;
  logic [23:0] a_in_re, a_in_im;
  logic [2:0]  a_rd_addr1, a_rd_addr2, a_wr_addr1, a_wr_addr2, a_out_idx;
  logic [23:0] a_rd_re1, a_rd_im1, a_rd_re2, a_rd_im2;
  logic [23:0] a_wr_re1, a_wr_im1, a_wr_re2, a_wr_im2;
  logic [23:0] a_out_re, a_out_im;

  // Instance B: DW=16, LOG2N=4, BITREV_IN=0
  logic        b_in_valid, b_in_ready, b_init_flag, b_rd_en, b_wr_en, b_cd;
  logic        b_out_valid, b_out_ready, b_out_last;
  logic [15:0] b_in_re, b_in_im;
  logic [3:0]  b_rd_addr1, b_rd_addr2, b_wr_addr1, b_wr_addr2, b_out_idx;
  logic [15:0] b_rd_re1, b_rd_im1, b_rd_re2, b_rd_im2;
  logic [15:0] b_wr_re1, b_wr_im1, b_wr_re2, b_wr_im2;
  logic [15:0] b_out_re, b_out_im;

  fft_data_ram_param #(.DW(24), .LOG2N(3), .BITREV_IN(1)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_re(a_in_re), .in_im(a_in_im),
    .init_flag(a_init_flag),
    .rd_en(a_rd_en), .rd_addr1(a_rd_addr1), .rd_addr2(a_rd_addr2),
    .rd_re1(a_rd_re1), .rd_im1(a_rd_im1), .rd_re2(a_rd_re2), .rd_im2(a_rd_im2),
    .wr_en(a_wr_en), .wr_addr1(a_wr_addr1), .wr_addr2(a_wr_addr2),
    .wr_re1(a_wr_re1), .wr_im1(a_wr_im1), .wr_re2(a_wr_re2), .wr_im2(a_wr_im2),
    .compute_done(a_cd),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_re(a_out_re), .out_im(a_out_im),
    .out_idx(a_out_idx), .out_last(a_out_last)
  );

  fft_data_ram_param #(.DW(16), .LOG2N(4), .BITREV_IN(0)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_re(b_in_re), .in_im(b_in_im),
    .init_flag(b_init_flag),
    .rd_en(b_rd_en), .rd_addr1(b_rd_addr1), .rd_addr2(b_rd_addr2),
    .rd_re1(b_rd_re1), .rd_im1(b_rd_im1), .rd_re2(b_rd_re2), .rd_im2(b_rd_im2),
    .wr_en(b_wr_en), .wr_addr1(b_wr_addr1), .wr_addr2(b_wr_addr2),
    .wr_re1(b_wr_re1), .wr_im1(b_wr_im1), .wr_re2(b_wr_re2), .wr_im2(b_wr_im2),
    .compute_done(b_cd),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_re(b_out_re), .out_im(b_out_im),
    .out_idx(b_out_idx), .out_last(b_out_last)
  );

  int checks = 0;
  int errors = 0;

  // Reference memories: {re, im} per natural address.
  logic [47:0] ma [8];
  logic [31:0] mb [16];
  // Expected registered read data of instance A.
  logic [47:0] exp_rd1, exp_rd2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit reversal by arithmetic: peel the low bits of k and push them onto r.
  function automatic int rev(input int k, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) r = r * 2 + ((k / (2 ** i)) % 2);
    return r;
  endfunction

  // Load 8 samples into A. toggle: in_valid pattern 1,0,1,0. ramp: re=k, im=-k.
  task automatic a_load(input bit toggle, input bit ramp);
    int k = 0;
    int cyc = 0;
    bit v;
    while (k < 8 && cyc < 100) begin
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      a_in_valid = v;
      a_in_re = ramp ? 24'(k) : 24'($urandom);
      a_in_im = ramp ? 24'(-k) : 24'($urandom);
      chk("a_load_in_ready", a_in_ready, 1);
      chk("a_load_init_flag", a_init_flag, 0);
      tick();
      cyc++;
      if (v) begin
        ma[rev(k, 3)] = {a_in_re, a_in_im};
        k++;
      end
    end
    a_in_valid = 1'b0;
    chk("a_load_count", k, 8);
    if (toggle) chk("a_load_cycles", cyc, 15);
    chk("a_after_load_in_ready", a_in_ready, 0);
    chk("a_after_load_init_flag", a_init_flag, 1);
  endtask

  task automatic a_compute_done();
    chk("a_pre_cd_out_valid", a_out_valid, 0);
    a_cd = 1'b1;
    tick();
    a_cd = 1'b0;
  endtask

  // mode 0: ready always 1; 1: ready pattern 1,0,0; 2: random ready.
  // stop_at >= 0: assert rst while that index is presented.
  task automatic a_unload(input int mode, input int stop_at, input bit check_seq);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    int seq [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    while (idx < 8 && cyc < 200) begin
      chk("a_unload_out_valid", a_out_valid, 1);
      chk("a_unload_out_idx", a_out_idx, idx);
      chk("a_unload_out_re", a_out_re, ma[idx][47:24]);
      chk("a_unload_out_im", a_out_im, ma[idx][23:0]);
      chk("a_unload_out_last", a_out_last, idx == 7);
      chk("a_unload_init_flag", a_init_flag, 1);
      if (check_seq) chk("a_unload_seq", a_out_re, seq[idx]);
      if (idx == stop_at) begin
        rst = 1'b1;
        a_out_ready = 1'b0;
        tick();
        rst = 1'b0;
        chk("a_rst_out_valid", a_out_valid, 0);
        chk("a_rst_in_ready", a_in_ready, 1);
        chk("a_rst_init_flag", a_init_flag, 0);
        chk("a_rst_out_idx", a_out_idx, 0);
        chk("a_rst_out_last", a_out_last, 0);
        chk("a_rst_out_re", a_out_re, 0);
        chk("a_rst_rd_re1", a_rd_re1, 0);
        exp_rd1 = '0;
        exp_rd2 = '0;
        return;
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom);
      a_out_ready = rdy;
      tick();
      cyc++;
      if (rdy) idx++;
    end
    a_out_ready = 1'b0;
    chk("a_unload_transfers", idx, 8);
    chk("a_end_out_valid", a_out_valid, 0);
    chk("a_end_in_ready", a_in_ready, 1);
    chk("a_end_init_flag", a_init_flag, 0);
  endtask

  task automatic a_check_rd(input string tag);
    chk({tag, "_re1"}, a_rd_re1, exp_rd1[47:24]);
    chk({tag, "_im1"}, a_rd_im1, exp_rd1[23:0]);
    chk({tag, "_re2"}, a_rd_re2, exp_rd2[47:24]);
    chk({tag, "_im2"}, a_rd_im2, exp_rd2[23:0]);
  endtask

  initial begin
    rst = 1'b1;
    {a_in_valid, a_rd_en, a_wr_en, a_cd, a_out_ready} = '0;
    {a_in_re, a_in_im, a_wr_re1, a_wr_im1, a_wr_re2, a_wr_im2} = '0;
    {a_rd_addr1, a_rd_addr2, a_wr_addr1, a_wr_addr2} = '0;
    {b_in_valid, b_rd_en, b_wr_en, b_cd, b_out_ready} = '0;
    {b_in_re, b_in_im, b_wr_re1, b_wr_im1, b_wr_re2, b_wr_im2} = '0;
    {b_rd_addr1, b_rd_addr2, b_wr_addr1, b_wr_addr2} = '0;
    exp_rd1 = '0;
    exp_rd2 = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_init_flag", a_init_flag, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_last", a_out_last, 0);
    chk("rst_out_idx", a_out_idx, 0);
    chk("rst_out_re", a_out_re, 0);
    chk("rst_out_im", a_out_im, 0);
    a_check_rd("rst_rd");
    chk("rst_b_in_ready", b_in_ready, 1);
    chk("rst_b_out_valid", b_out_valid, 0);

    // Ramp load with toggling valid; unload with stalled ready
    a_load(1'b1, 1'b1);
    a_compute_done();
    a_unload(1, -1, 1'b1);

    // rd_en and compute_done in LOAD are ignored
    a_rd_en = 1'b1;
    a_rd_addr1 = 3'd1;
    a_rd_addr2 = 3'd2;
    a_cd = 1'b1;
    tick();
    a_rd_en = 1'b0;
    a_cd = 1'b0;
    a_check_rd("load_rd_ignored");
    chk("load_cd_ignored_out_valid", a_out_valid, 0);
    chk("load_cd_ignored_in_ready", a_in_ready, 1);

    // Random load, then read-before-write directed case
    a_load(1'b0, 1'b0);
    exp_rd1 = ma[2];
    exp_rd2 = ma[5];
    a_wr_en = 1'b1;
    a_wr_addr1 = 3'd2;
    a_wr_addr2 = 3'd5;
    a_wr_re1 = 24'h000100;
    a_wr_im1 = 24'($urandom);
    a_wr_re2 = 24'h000200;
    a_wr_im2 = 24'($urandom);
    a_rd_en = 1'b1;
    a_rd_addr1 = 3'd2;
    a_rd_addr2 = 3'd5;
    tick();
    a_wr_en = 1'b0;
    ma[2] = {a_wr_re1, a_wr_im1};
    ma[5] = {a_wr_re2, a_wr_im2};
    a_check_rd("rbw_old");
    exp_rd1 = ma[2];
    exp_rd2 = ma[5];
    tick();
    a_check_rd("rbw_new");
    chk("rbw_new_re1_const", a_rd_re1, 24'h000100);
    chk("rbw_new_re2_const", a_rd_re2, 24'h000200);
    a_rd_en = 1'b0;
    a_rd_addr1 = 3'd0;
    a_rd_addr2 = 3'd7;
    tick();
    a_check_rd("rd_hold");

    // Random butterfly traffic against the reference memory
    for (int i = 0; i < 40; i++) begin
      a_rd_en = 1'($urandom);
      a_wr_en = 1'($urandom);
      a_rd_addr1 = 3'($urandom);
      a_rd_addr2 = 3'($urandom);
      a_wr_addr1 = 3'($urandom);
      a_wr_addr2 = 3'($urandom);
      a_wr_re1 = 24'($urandom);
      a_wr_im1 = 24'($urandom);
      a_wr_re2 = 24'($urandom);
      a_wr_im2 = 24'($urandom);
      if (a_rd_en) begin
        exp_rd1 = ma[a_rd_addr1];
        exp_rd2 = ma[a_rd_addr2];
      end
      if (a_wr_en) begin
        ma[a_wr_addr1] = {a_wr_re1, a_wr_im1};
        ma[a_wr_addr2] = {a_wr_re2, a_wr_im2};
      end
      tick();
      a_check_rd("rand_rd");
    end
    a_rd_en = 1'b0;
    a_wr_en = 1'b0;
    a_compute_done();
    a_unload(2, -1, 1'b0);

    // Reset at the 3rd unload sample, then a full reload and unload
    a_load(1'b0, 1'b0);
    a_compute_done();
    a_unload(0, 2, 1'b0);
    a_load(1'b0, 1'b0);
    a_compute_done();
    a_unload(0, -1, 1'b0);

    // Instance B: natural-order load of 16, same-address dual write
    begin
      int k = 0;
      int cyc = 0;
      while (k < 16 && cyc < 100) begin
        b_in_valid = 1'b1;
        b_in_re = 16'(k);
        b_in_im = 16'($urandom);
        tick();
        cyc++;
        mb[k] = {b_in_re, b_in_im};
        k++;
      end
      b_in_valid = 1'b0;
      chk("b_after_load_in_ready", b_in_ready, 0);
      chk("b_after_load_init_flag", b_init_flag, 1);
      b_wr_en = 1'b1;
      b_wr_addr1 = 4'd3;
      b_wr_addr2 = 4'd3;
      b_wr_re1 = 16'h1111;
      b_wr_im1 = 16'($urandom);
      b_wr_re2 = 16'h2222;
      b_wr_im2 = 16'($urandom);
      tick();
      b_wr_en = 1'b0;
      mb[3] = {b_wr_re2, b_wr_im2};
      b_cd = 1'b1;
      tick();
      b_cd = 1'b0;
      k = 0;
      cyc = 0;
      while (k < 16 && cyc < 300) begin
        bit rdy;
        chk("b_unload_out_valid", b_out_valid, 1);
        chk("b_unload_out_idx", b_out_idx, k);
        chk("b_unload_out_re", b_out_re, mb[k][31:16]);
        chk("b_unload_out_im", b_out_im, mb[k][15:0]);
        chk("b_unload_out_last", b_out_last, k == 15);
        chk("b_unload_natural", b_out_re, (k == 3) ? 16'h2222 : 16'(k));
        rdy = 1'($urandom);
        b_out_ready = rdy;
        tick();
        cyc++;
        if (rdy) k++;
      end
      b_out_ready = 1'b0;
      chk("b_unload_transfers", k, 16);
      chk("b_end_out_valid", b_out_valid, 0);
      chk("b_end_in_ready", b_in_ready, 1);
      chk("b_end_init_flag", b_init_flag, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_data_ram_param.md
Name: fft_data_ram_param

Overview:
- Parametrised working memory for an in-place radix-2 FFT. Generalises the 8-point, 24-bit data RAM to N = 2^LOG2N points and configurable width.
- Loads N complex samples through a valid/ready stream. Bit-reversal is done on the fly at load, so there is no separate reorder pass.
- Serves the butterfly engine with dual read and dual write ports.
- After a compute-done strobe, streams results out in natural order with backpressure.

Parameters:
- DW, 24, width of the real part and of the imaginary part (signed, two's complement).
- LOG2N, 3, log2 of point count; legal range 2..10; N = 2^LOG2N.
- BITREV_IN, 1, 1 = load sample k at address bitrev(k); 0 = load at address k (natural order).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  load sample valid
- in_ready  out  1  high while in LOAD state
- in_re, in_im  in  DW each  load sample
- init_flag  out  1  high from load completion until UNLOAD completes
- rd_en  in  1  butterfly read strobe
- rd_addr1, rd_addr2  in  LOG2N each  butterfly read addresses
- rd_re1, rd_im1, rd_re2, rd_im2  out  DW each  registered read data
- wr_en  in  1  butterfly write strobe
- wr_addr1, wr_addr2  in  LOG2N each  butterfly write addresses
- wr_re1, wr_im1, wr_re2, wr_im2  in  DW each  butterfly results
- compute_done  in  1  single-cycle strobe: FFT finished, start unload
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accept
- out_re, out_im  out  DW each  output sample
- out_idx  out  LOG2N  natural-order index of the current output sample
- out_last  out  1  high with the sample at index N-1

Behaviour:
- Storage: N words of 2*DW bits, with real part in the high half. Memory is not cleared by rst.
- Reset (rst=1 at a clock edge), required values:
  - state = LOAD, load/unload counters = 0
  - in_ready=1, init_flag=0, out_valid=0, out_last=0, out_idx=0
  - rd_re*/rd_im*/out_re/out_im = 0
- Reset mid-operation aborts any state and behaves exactly as above.
- LOAD state:
  - Each cycle with in_valid & in_ready writes the sample to bitrev(cnt) (or to cnt when BITREV_IN=0), then cnt increments.
  - On the N-th accepted sample: go to COMPUTE, set init_flag=1 on the next cycle, drop in_ready in the same transition.
  - in_valid=0 cycles are stalls and have no effect.
- COMPUTE state:
  - rd_en=1: rd_* outputs take mem[rd_addr1] and mem[rd_addr2] on the next edge (latency 1). With rd_en=0, rd_* hold their value.
  - wr_en=1: mem[wr_addr1] <= wr_*1 and mem[wr_addr2] <= wr_*2 at the edge.
  - rd_en and wr_en together: both occur. Reads return pre-write data (read-before-write); there is no bypass.
  - wr_addr1 == wr_addr2 with wr_en: port 2 data wins.
  - compute_done -> go to UNLOAD.
  - rd_en/wr_en outside COMPUTE are ignored.
- UNLOAD state:
  - Output register is loaded from mem[0] on entry, with out_valid=1 one cycle after compute_done.
  - A sample transfers on out_valid & out_ready. On transfer, the register advances to the next index (1 sample/cycle sustained).
  - While out_ready=0, out_re/out_im/out_idx/out_last hold stable.
  - After the transfer with out_last: out_valid=0, init_flag=0, return to LOAD, in_ready=1 on the next cycle, cnt=0.
- Unload order is always natural index order, regardless of BITREV_IN.
- compute_done in LOAD or UNLOAD: ignored.
- No arithmetic is performed; data is stored and returned bit-exact.

Test Plan:
- N=8, BITREV_IN=1, load samples re=k, im=-k for k=0..7. Then compute_done with no writes. Required unload out_re sequence 0,4,2,6,1,5,3,7, with out_last on the 8th sample, and init_flag high from the cycle after the 8th load until the last transfer.
- Load continuous with in_valid toggling 1,0,1,0: 8 samples accepted in 15 cycles; in_ready=0 from the cycle after the 8th acceptance.
- COMPUTE: wr_en with addr1=2, addr2=5, data 0x000100/0x000200, and rd_en of 2,5 in the same cycle. Required: rd_re1/rd_re2 show the old values. rd_en the next cycle returns 0x000100/0x000200.
- Unload with out_ready pattern 1,0,0,1,...: out_idx and out_re are held during the low cycles; exactly 8 transfers; return to LOAD.
- rst asserted at the 3rd UNLOAD sample: next cycle out_valid=0, in_ready=1, init_flag=0. Reload of 8 samples and a new compute_done restart the unload at index 0.
- LOG2N=4, BITREV_IN=0, DW=16: load re=k for k=0..15. Required unload 0..15 in order, with wr_addr1==wr_addr2=3 storing the port-2 value.
